psx_pad_responder: RTL and testbench

- Controller-side counterpart of the PSX host/poller. Drives the host's `data` and `ack` inputs and consumes its `psx_clk`, `cmd` and `att` outputs.
- Emulates a digital pad, so host logic can be brought up and tested without a physical controller.
- Runs on a system clock much faster than `psx_clk`. All pad-side inputs are oversampled through synchronisers.

---
 rtl/psx_pad_responder.sv | 212 +++++++++++++++++++++
 tb/tb_psx_pad_responder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/psx_pad_responder.sv
// Digital (optionally analog) PSX pad emulator answering a host poller over the
// psx_clk/cmd/att/data/ack link. Define PSX_PAD_ANALOG_EN for the 9-byte analog frame.
module psx_pad_responder #(
   parameter int         ACK_DELAY = 8,
   parameter int         ACK_LEN   = 4,
   parameter logic [7:0] PAD_ID    = 8'h41
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        psx_clk,
   input  logic        cmd,
   input  logic        att,
   input  logic [15:0] buttons,
`ifdef PSX_PAD_ANALOG_EN
   input  logic [31:0] sticks,
`endif
   output logic        data,
   output logic        ack,
   output logic        busy,
   output logic        cmd_err
);

   localparam int CMAX = (ACK_DELAY > ACK_LEN) ? ACK_DELAY : ACK_LEN;
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [CW-1:0] DLY_LAST = CW'(ACK_DELAY - 1);
   localparam logic [CW-1:0] LEN_LAST = CW'(ACK_LEN - 1);
`ifdef PSX_PAD_ANALOG_EN
   localparam int         PW        = 48;
   localparam logic [3:0] LAST_BYTE = 4'd8;
   localparam logic [7:0] ID_BYTE   = 8'h73;
`else
   localparam int         PW        = 16;
   localparam logic [3:0] LAST_BYTE = 4'd4;
   localparam logic [7:0] ID_BYTE   = PAD_ID;
`endif

   typedef enum logic [2:0] {IDLE, SHIFT, ACK_WAIT, ACK_PULSE, DONE} state_t;

   state_t          state_q, state_d;
   logic [3:0]      bit_idx_q, bit_idx_d;
   logic [3:0]      byte_idx_q, byte_idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            data_q, data_d;
   logic            err_q, err_d;
   logic [7:0]      rx_q, rx_d;
   logic [7:0]      tx_q, tx_d;
   logic [PW-1:0]   pay_q, pay_d;
   logic [2:0]      clk_s_q;
   logic [1:0]      cmd_s_q;
   logic [2:0]      att_s_q;
   logic [1:0]      fill_q;
   logic            armed_q;
   logic [PW-1:0]   pay_live;

   logic clk_rise, clk_fall, att_rise, att_fall;

`ifdef PSX_PAD_ANALOG_EN
   assign pay_live = {sticks, buttons};
`else
   assign pay_live = buttons;
`endif

   function automatic logic [7:0] reply(input logic [3:0] idx, input logic [PW-1:0] pay);
      logic [7:0] r;
      case (idx)
         4'd0:    r = 8'hFF;
         4'd1:    r = ID_BYTE;
         4'd2:    r = 8'h5A;
         4'd3:    r = ~pay[7:0];
         4'd4:    r = ~pay[15:8];
`ifdef PSX_PAD_ANALOG_EN
         4'd5:    r = pay[23:16];
         4'd6:    r = pay[31:24];
         4'd7:    r = pay[39:32];
         4'd8:    r = pay[47:40];
`endif
         default: r = 8'hFF;
      endcase
      return r;
   endfunction

   // bit0 = first sync stage, bit1 = synchronised value, bit2 = previous synchronised value
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         clk_s_q <= '1;
         cmd_s_q <= '1;
         att_s_q <= '1;
         fill_q  <= '0;
         armed_q <= 1'b0;
      end else begin
         clk_s_q <= {clk_s_q[1:0], psx_clk};
         cmd_s_q <= {cmd_s_q[0], cmd};
         att_s_q <= {att_s_q[1:0], att};
         fill_q  <= {fill_q[0], 1'b1};
         // A frame may only start after att has genuinely been seen high post-reset.
         if (fill_q[1] && att_s_q[1]) armed_q <= 1'b1;
      end
   end

   assign clk_rise = clk_s_q[1] & ~clk_s_q[2];
   assign clk_fall = ~clk_s_q[1] & clk_s_q[2];
   assign att_rise = att_s_q[1] & ~att_s_q[2];
   assign att_fall = armed_q & ~att_s_q[1] & att_s_q[2];

   always_comb begin
      state_d    = state_q;
      bit_idx_d  = bit_idx_q;
      byte_idx_d = byte_idx_q;
      cnt_d      = cnt_q;
      data_d     = data_q;
      err_d      = 1'b0;
      rx_d       = rx_q;
      tx_d       = tx_q;
      pay_d      = pay_q;
      if (att_rise) begin
         state_d    = IDLE;
         data_d     = 1'b1;
         bit_idx_d  = '0;
         byte_idx_d = '0;
         cnt_d      = '0;
      end else begin
         case (state_q)
            IDLE: begin
               data_d = 1'b1;
               if (att_fall) begin
                  pay_d      = pay_live;
                  byte_idx_d = '0;
                  bit_idx_d  = '0;
                  tx_d       = 8'hFF;
                  data_d     = 1'b1;
                  state_d    = SHIFT;
               end
            end
            SHIFT: begin
               if (clk_rise) begin
                  rx_d = {cmd_s_q[1], rx_q[7:1]};
                  if (bit_idx_q < 4'd8) bit_idx_d = bit_idx_q + 4'd1;
                  if (bit_idx_d == 4'd8) begin
                     if ((byte_idx_q == 4'd0 && rx_d != 8'h01) ||
                         (byte_idx_q == 4'd1 && rx_d != 8'h42)) begin
                        err_d   = 1'b1;
                        data_d  = 1'b1;
                        state_d = DONE;
                     end else if (byte_idx_q == LAST_BYTE) begin
                        data_d  = 1'b1;
                        state_d = DONE;
                     end else begin
                        cnt_d   = '0;
                        state_d = ACK_WAIT;
                     end
                  end
               end else if (clk_fall && bit_idx_q < 4'd8) begin
                  data_d = tx_q[bit_idx_q[2:0]];
               end
            end
            ACK_WAIT: begin
               if (cnt_q == DLY_LAST) begin
                  byte_idx_d = byte_idx_q + 4'd1;
                  bit_idx_d  = '0;
                  tx_d       = reply(byte_idx_d, pay_q);
                  data_d     = tx_d[0];
                  cnt_d      = '0;
                  state_d    = ACK_PULSE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ACK_PULSE: begin
               if (cnt_q == LEN_LAST) begin
                  cnt_d   = '0;
                  state_d = SHIFT;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            DONE:    data_d = 1'b1;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         bit_idx_q  <= '0;
         byte_idx_q <= '0;
         cnt_q      <= '0;
         data_q     <= 1'b1;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_idx_q  <= bit_idx_d;
         byte_idx_q <= byte_idx_d;
         cnt_q      <= cnt_d;
         data_q     <= data_d;
         err_q      <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      rx_q  <= rx_d;
      tx_q  <= tx_d;
      pay_q <= pay_d;
   end

   // Abort overrides the registered outputs in the cycle the att rise is seen.
   assign data    = data_q | att_rise;
   assign ack     = (state_q == ACK_PULSE) & ~att_rise;
   assign busy    = (state_q != IDLE);
   assign cmd_err = err_q;

endmodule

// File: tb/tb_psx_pad_responder.sv
// Bench for psx_pad_responder: a host model clocks frames out and a scoreboard
// queue holds the reply bytes expected from the pad.
module tb_psx_pad_responder;
   localparam int ACK_LEN = 4;
   localparam int HALF    = 8;
`ifdef PSX_PAD_ANALOG_EN
   localparam int         NB   = 9;
   localparam logic [7:0] ID_B = 8'h73;
`else
   localparam int         NB   = 5;
   localparam logic [7:0] ID_B = 8'h41;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b0;
   logic        psx_clk = 1'b1;
   logic        cmd = 1'b1;
   logic        att = 1'b1;
   logic [15:0] buttons = 16'h0000;
   logic [31:0] sticks = 32'h8080_8080;
   logic        data, ack, busy, cmd_err;

   psx_pad_responder #(.ACK_DELAY(8), .ACK_LEN(ACK_LEN), .PAD_ID(8'h41)) dut (
      .clk(clk), .rst_n(rst_n), .psx_clk(psx_clk), .cmd(cmd), .att(att),
      .buttons(buttons),
`ifdef PSX_PAD_ANALOG_EN
      .sticks(sticks),
`endif
      .data(data), .ack(ack), .busy(busy), .cmd_err(cmd_err));

   logic [7:0] exp_q[$];
   int n_cmp = 0;
   int n_fail = 0;

   int   ack_pulses = 0;
   int   ack_badlen = 0;
   int   err_pulses = 0;
   int   run = 0;
   logic ack_prev = 1'b0;

   always @(negedge clk) begin
      if (ack) run <= run + 1;
      else begin
         if (ack_prev && run != ACK_LEN) ack_badlen <= ack_badlen + 1;
         run <= 0;
      end
      if (ack && !ack_prev) ack_pulses <= ack_pulses + 1;
      if (cmd_err) err_pulses <= err_pulses + 1;
      ack_prev <= ack;
   end

   initial begin
      #3_000_000;
      $display("FAIL global_timeout: simulation time exceeded");
      $fatal(1, "timeout");
   end

   task automatic push_frame(input logic [15:0] btn);
      exp_q.push_back(8'hFF);
      exp_q.push_back(ID_B);
      exp_q.push_back(8'h5A);
      exp_q.push_back(~btn[7:0]);
      exp_q.push_back(~btn[15:8]);
`ifdef PSX_PAD_ANALOG_EN
      exp_q.push_back(sticks[7:0]);
      exp_q.push_back(sticks[15:8]);
      exp_q.push_back(sticks[23:16]);
      exp_q.push_back(sticks[31:24]);
`endif
   endtask

   task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = 8'hFF;
      for (int i = 0; i < nbits; i++) begin
         psx_clk = 1'b0;
         cmd = tx[i];
         repeat (HALF) @(negedge clk);
         rx[i] = data;
         psx_clk = 1'b1;
         repeat (HALF) @(negedge clk);
      end
   endtask

   task automatic wait_ack(input string tag);
      int t;
      t = 0;
      while (!ack && t < 100) begin @(negedge clk); t++; end
      n_cmp++;
      if (!ack) begin
         n_fail++;
         $display("FAIL %s ack_timeout: ack=%0b required 1", tag, ack);
      end
      t = 0;
      while (ack && t < 100) begin @(negedge clk); t++; end
   endtask

   task automatic pop_cmp(input string tag, input int k, input logic [7:0] r);
      logic [7:0] e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s byte%0d: got %02h, scoreboard empty", tag, k, r);
      end else begin
         e = exp_q.pop_front();
         if (r !== e) begin
            n_fail++;
            $display("FAIL %s byte%0d: got %02h required %02h", tag, k, r, e);
         end
      end
   endtask

   task automatic do_frame(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                           input bit acks, input logic [15:0] btn_after);
      logic [7:0] r;
      att = 1'b0;
      repeat (10) @(negedge clk);
      buttons = btn_after;
      for (int k = 0; k < NB; k++) begin
         xfer((k == 0) ? b0 : ((k == 1) ? b1 : 8'h00), 8, r);
         pop_cmp(tag, k, r);
         if (acks && k < NB - 1) wait_ack(tag);
         else repeat (20) @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp += 4;
      if (data !== 1'b1) begin n_fail++; $display("FAIL reset_data: got %b required 1", data); end
      if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b required 0", ack); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
      if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_err: got %b required 0", cmd_err); end
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_digital;
      int a0, b0, e0;
      a0 = ack_pulses; b0 = ack_badlen; e0 = err_pulses;
      buttons = 16'h0008;
      push_frame(16'h0008);
      do_frame("digital", 8'h01, 8'h42, 1'b1, 16'h0008);
      n_cmp += 4;
      if (ack_pulses - a0 != NB - 1) begin n_fail++; $display("FAIL digital_ack_count: got %0d required %0d", ack_pulses - a0, NB - 1); end
      if (ack_badlen != b0) begin n_fail++; $display("FAIL digital_ack_len: %0d pulses not %0d clks long", ack_badlen - b0, ACK_LEN); end
      if (err_pulses != e0) begin n_fail++; $display("FAIL digital_cmd_err: got %0d pulses required 0", err_pulses - e0); end
      if (busy !== 1'b1) begin n_fail++; $display("FAIL digital_busy_done: got %b required 1", busy); end
      att = 1'b1;
      @(negedge clk); @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL digital_busy_hold: got %b required 1", busy); end
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL digital_busy_fall: got %b required 0", busy); end
      repeat (10) @(negedge clk);
   endtask

   task automatic test_cmd_err;
      int a0, e0;
      a0 = ack_pulses; e0 = err_pulses;
      for (int k = 0; k < NB; k++) exp_q.push_back(8'hFF);
      do_frame("cmd_err", 8'h81, 8'h42, 1'b0, buttons);
      n_cmp += 3;
      if (err_pulses - e0 != 1) begin n_fail++; $display("FAIL cmd_err_pulses: got %0d required 1", err_pulses - e0); end
      if (ack_pulses != a0) begin n_fail++; $display("FAIL cmd_err_acks: got %0d required 0", ack_pulses - a0); end
      if (busy !== 1'b1) begin n_fail++; $display("FAIL cmd_err_busy: got %b required 1", busy); end
      att = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_abort;
      logic [7:0] r;
      buttons = 16'hA5C3;
      exp_q.push_back(8'hFF);
      exp_q.push_back(ID_B);
      att = 1'b0;
      repeat (10) @(negedge clk);
      xfer(8'h01, 8, r); pop_cmp("abort", 0, r); wait_ack("abort");
      xfer(8'h42, 8, r); pop_cmp("abort", 1, r); wait_ack("abort");
      xfer(8'h00, 3, r);
      att = 1'b1;
      repeat (4) @(negedge clk);
      n_cmp += 3;
      if (data !== 1'b1) begin n_fail++; $display("FAIL abort_data: got %b required 1", data); end
      if (ack !== 1'b0) begin n_fail++; $display("FAIL abort_ack: got %b required 0", ack); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b required 0", busy); end
      repeat (6) @(negedge clk);
      push_frame(16'hA5C3);
      do_frame("abort_new", 8'h01, 8'h42, 1'b1, 16'hA5C3);
      att = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_latch;
      buttons = 16'h0000;
      push_frame(16'h0000);
      do_frame("latch", 8'h01, 8'h42, 1'b1, 16'hFFFF);
      att = 1'b1;
      repeat (10) @(negedge clk);
      push_frame(16'hFFFF);
      do_frame("latch_next", 8'h01, 8'h42, 1'b1, 16'hFFFF);
      att = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_reset_mid;
      logic [7:0] r;
      int t, a0;
      buttons = 16'h1234;
      att = 1'b0;
      repeat (10) @(negedge clk);
      exp_q.push_back(8'hFF);
      xfer(8'h01, 8, r); pop_cmp("rst_mid", 0, r);
      t = 0;
      while (!ack && t < 100) begin @(negedge clk); t++; end
      n_cmp++;
      if (!ack) begin n_fail++; $display("FAIL rst_mid_ack_start: got %b required 1", ack); end
      rst_n = 1'b0;
      @(negedge clk);
      n_cmp += 3;
      if (ack !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ack: got %b required 0", ack); end
      if (data !== 1'b1) begin n_fail++; $display("FAIL rst_mid_data: got %b required 1", data); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b required 0", busy); end
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      xfer(8'h01, 8, r);
      n_cmp += 2;
      if (r !== 8'hFF) begin n_fail++; $display("FAIL rst_mid_silent_data: got %02h required ff", r); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_silent_busy: got %b required 0", busy); end
      att = 1'b1;
      repeat (10) @(negedge clk);
      a0 = ack_pulses;
      push_frame(16'h1234);
      do_frame("rst_mid_new", 8'h01, 8'h42, 1'b1, 16'h1234);
      n_cmp++;
      if (ack_pulses - a0 != NB - 1) begin n_fail++; $display("FAIL rst_mid_new_acks: got %0d required %0d", ack_pulses - a0, NB - 1); end
      att = 1'b1;
      repeat (10) @(negedge clk);
   endtask

`ifdef PSX_PAD_ANALOG_EN
   task automatic test_analog;
      int a0;
      a0 = ack_pulses;
      sticks = 32'h8080_00FF;
      buttons = 16'h0000;
      push_frame(16'h0000);
      do_frame("analog", 8'h01, 8'h42, 1'b1, 16'h0000);
      n_cmp++;
      if (ack_pulses - a0 != 8) begin n_fail++; $display("FAIL analog_acks: got %0d required 8", ack_pulses - a0); end
      att = 1'b1;
      repeat (10) @(negedge clk);
   endtask
`endif

   initial begin
      @(negedge clk);
      test_reset;
      test_digital;
      test_cmd_err;
      test_abort;
      test_latch;
      test_reset_mid;
`ifdef PSX_PAD_ANALOG_EN
      test_analog;
`endif
      n_cmp++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d bytes left, required 0", exp_q.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
